uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
//  UART receive front end: oversamples the asynchronous serial line rx, deserializes 8N1 frames
//  and hands each byte to the receive FIFO controller (UARTFIFORX) directly downstream.
//  Output contract: d_out holds the byte, rx_done is a one-clk strobe on d_out/rx_done inputs.
//  Contains its own baud-tick generator (16x oversampling), input synchronizer, framing check.
// PARAMETERS
//  DBIT     8    data bits per frame, LSB first
//  SB_TICK  16   oversample ticks in the stop bit (16 = 1 stop bit)
//  BAUD_DIV 326  clk cycles per oversample tick (50 MHz / (16*9600) ~ 326)
// PORTS
//  clk        in   1     system clock, rising edge
//  reset      in   1     asynchronous, active-low reset (0 = reset)
//  rx         in   1     serial line, idle high, asynchronous to clk
//  d_out      out  DBIT  last correctly received byte
//  rx_done    out  1     one-clk pulse: d_out holds a new valid byte
//  frame_err  out  1     one-clk pulse: stop bit sampled low, byte discarded
// BEHAVIOUR
//  Reset (reset=0, async): d_out=0, rx_done=0, frame_err=0, tick counter=0, state IDLE,
//   both synchronizer flops=1 (line idle). Registers named current_state/s/n/b (bench probes).
//  rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s (+2 clk latency).
//  Tick gen: free-running count 0..BAUD_DIV-1; tick=1 for one clk when count==BAUD_DIV-1.
//  s = tick count within bit (4b), n = data bit index, b = DBIT shift register.
//  States:
//   IDLE   : rx_s==0 -> START, s=0 (checked every clk, not only on ticks).
//   START  : on tick: s==7 -> rx_s==0 ? (DATA, s=0, n=0) : IDLE (glitch reject); else s++.
//   DATA   : on tick: s==15 -> s=0, b={rx_s,b[DBIT-1:1]}; n==DBIT-1 -> STOP else n++; else s++.
//   STOP   : on tick: s==SB_TICK-1 -> rx_s==1 ? (IDLE, d_out<=b, rx_done<=1)
//            : (BREAK, frame_err<=1, d_out unchanged); else s++.
//   BREAK  : stay until rx_s==1, then IDLE (a held-low line never retriggers START).
//  rx_done/frame_err are registered, high exactly one clk, never both, not repeated.
//  d_out stable from rx_done until the next good frame's rx_done (consumer may sample late).
//  Sampling point: mid-bit (8 ticks after falling edge detected, then every 16 ticks).
//  Latency: rx_done rises 2 + BAUD_DIV*(8+16*DBIT+SB_TICK) clks (+/- BAUD_DIV) after the start
//   edge; IDLE reached same clk, so back-to-back frames (no idle gap) are received.
//  No flow control: a new frame overwrites d_out; consumer must take each byte on rx_done.
//  Reset mid-frame: immediate abort to IDLE, partial byte dropped, no strobe emitted.
//  Undefined state encodings recover to IDLE (default branch).
// TESTING  (BAUD_DIV=4 -> bit time 64 clks, clk period 10 ns)
//  1 reset=0 for 3 clks -> d_out=0, rx_done=0, frame_err=0, current_state=IDLE; hold rx=1 1000 clks -> no strobes.
//  2 frame 0x32 (start,0,1,0,0,1,1,0,0,stop) -> exactly one 1-clk rx_done, d_out=8'h32, frame_err stays 0.
//  3 rx low 12 clks then high -> START then IDLE, no rx_done/frame_err; next frame 0x5A -> d_out=8'h5A.
//  4 frame 0xA5 with stop bit 0, rx held low 200 clks -> one frame_err pulse, no rx_done, d_out keeps 8'h5A,
//    state BREAK throughout; rx=1 -> IDLE; frame 0x3C -> rx_done, d_out=8'h3C.
//  5 frames 0x00 then 0xFF back-to-back, no idle gap -> two rx_done pulses, d_out=8'h00 then 8'hFF.
//  6 reset=0 pulse during DATA bit 4 of 0x81 -> IDLE at once, no rx_done; next frame 0x81 -> d_out=8'h81.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 16x oversampling UART 8N1 receiver with framing check
module uart_rx_deserializer #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 326
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            frame_err
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);
    localparam logic [3:0]    S_MID   = 4'd7;
    localparam logic [3:0]    S_BIT   = 4'd15;
    localparam logic [3:0]    S_STOP  = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t          current_state, next_state;
    logic [3:0]      s, s_d;
    logic [NW-1:0]   n, n_d;
    logic [DBIT-1:0] b, b_d;

    logic            rx_meta_q, rx_s_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick;
    logic [DBIT-1:0] d_out_q, d_out_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Synchronizer flops reset high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_state <= IDLE;
            s             <= '0;
            n             <= '0;
            b             <= '0;
            d_out_q       <= '0;
            rx_done_q     <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            current_state <= next_state;
            s             <= s_d;
            n             <= n_d;
            b             <= b_d;
            d_out_q       <= d_out_d;
            rx_done_q     <= rx_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    always_comb begin
        next_state = current_state;
        s_d        = s;
        n_d        = n;
        b_d        = b;
        case (current_state)
            IDLE: begin
                if (!rx_s_q) begin
                    next_state = START;
                    s_d        = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s == S_MID) begin
                        if (!rx_s_q) begin
                            next_state = DATA;
                            s_d        = '0;
                            n_d        = '0;
                        end else begin
                            next_state = IDLE;
                        end
                    end else begin
                        s_d = s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == S_BIT) begin
                        s_d = '0;
                        b_d = {rx_s_q, b[DBIT-1:1]};
                        if (n == N_LAST) next_state = STOP;
                        else             n_d = n + NW'(1);
                    end else begin
                        s_d = s + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == S_STOP) next_state = rx_s_q ? IDLE : BREAK;
                    else             s_d = s + 4'd1;
                end
            end
            // A line held low must return high before another start can be seen.
            BREAK: begin
                if (rx_s_q) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        d_out_d     = d_out_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        if (current_state == STOP && tick && s == S_STOP) begin
            if (rx_s_q) begin
                d_out_d   = b;
                rx_done_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign d_out     = d_out_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - directed frames checked against a frame-level receive model
module tb_uart_rx_deserializer;

    localparam int BD      = 4;
    localparam int BIT_CLK = 16 * BD;
    localparam int LAT     = 2 + BD * (8 + 16 * 8 + 16);
    localparam int ST_IDLE  = 0;
    localparam int ST_START = 1;
    localparam int ST_BREAK = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;

    uart_rx_deserializer #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(BD)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .d_out(d_out), .rx_done(rx_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         start;
    } ev_t;

    ev_t        q[$];
    ev_t        ev;
    int         cyc = 0;
    int         pass_cnt = 0;
    int         tot_cnt = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] exp_dout = 8'h00;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Frame-level model: each frame sent yields exactly one strobe within the latency window.
    always @(negedge clk) begin
        if (!reset) begin
            exp_dout = 8'h00;
            chk("reset_outputs", {22'd0, d_out, rx_done, frame_err}, 32'd0);
        end else begin
            if (rx_done && frame_err) chk("both_strobes", 32'd1, 32'd0);
            if (rx_done || frame_err) begin
                if (rx_done) done_cnt++;
                if (frame_err) err_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, rx_done, frame_err}, 32'd0);
                end else begin
                    ev = q.pop_front();
                    chk("strobe_kind_frame_err", {31'd0, frame_err}, {31'd0, ev.err});
                    chk("strobe_latency_window",
                        32'((cyc - ev.start >= LAT - BD) && (cyc - ev.start <= LAT + BD)), 32'd1);
                    if (rx_done) exp_dout = ev.data;
                end
            end else if (q.size() > 0 && cyc > q[0].start + LAT + BD) begin
                chk("strobe_timeout", 32'd0, 32'd1);
                void'(q.pop_front());
            end
            chk("d_out_model", {24'd0, d_out}, {24'd0, exp_dout});
        end
    end

    task automatic wait_clk(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic send_data(input logic [7:0] v);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            wait_clk(BIT_CLK);
        end
    endtask

    task automatic send_frame(input logic [7:0] v);
        ev_t e;
        e.err = 1'b0; e.data = v; e.start = cyc;
        q.push_back(e);
        send_data(v);
        rx = 1'b1;
        wait_clk(BIT_CLK);
    endtask

    int d0, e0;

    initial begin
        wait_clk(3);
        chk("reset_state_idle", 32'(dut.current_state), ST_IDLE);
        chk("reset_d_out", {24'd0, d_out}, 32'd0);
        chk("reset_strobes", {30'd0, rx_done, frame_err}, 32'd0);
        reset = 1'b1;

        d0 = done_cnt; e0 = err_cnt;
        wait_clk(1000);
        chk("idle_no_rx_done", 32'(done_cnt - d0), 32'd0);
        chk("idle_no_frame_err", 32'(err_cnt - e0), 32'd0);

        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h32);
        chk("frame32_one_done", 32'(done_cnt - d0), 32'd1);
        chk("frame32_no_err", 32'(err_cnt - e0), 32'd0);
        chk("frame32_d_out", {24'd0, d_out}, 32'h32);

        d0 = done_cnt; e0 = err_cnt;
        rx = 1'b0;
        wait_clk(8);
        chk("glitch_in_start", 32'(dut.current_state), ST_START);
        wait_clk(4);
        rx = 1'b1;
        wait_clk(60);
        chk("glitch_back_idle", 32'(dut.current_state), ST_IDLE);
        chk("glitch_no_strobes", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
        send_frame(8'h5A);
        chk("frame5a_d_out", {24'd0, d_out}, 32'h5A);

        d0 = done_cnt; e0 = err_cnt;
        ev.err = 1'b1; ev.data = 8'hA5; ev.start = cyc;
        q.push_back(ev);
        send_data(8'hA5);
        rx = 1'b0;
        wait_clk(64);
        for (int i = 0; i < 136; i++) begin
            wait_clk(1);
            chk("break_held", 32'(dut.current_state), ST_BREAK);
        end
        chk("break_one_err", 32'(err_cnt - e0), 32'd1);
        chk("break_no_done", 32'(done_cnt - d0), 32'd0);
        chk("break_d_out_kept", {24'd0, d_out}, 32'h5A);
        rx = 1'b1;
        wait_clk(5);
        chk("break_release_idle", 32'(dut.current_state), ST_IDLE);
        send_frame(8'h3C);
        chk("frame3c_d_out", {24'd0, d_out}, 32'h3C);

        d0 = done_cnt;
        send_frame(8'h00);
        chk("b2b_first_d_out", {24'd0, d_out}, 32'h00);
        send_frame(8'hFF);
        chk("b2b_two_done", 32'(done_cnt - d0), 32'd2);
        chk("b2b_second_d_out", {24'd0, d_out}, 32'hFF);

        d0 = done_cnt; e0 = err_cnt;
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            wait_clk(BIT_CLK);
        end
        rx = 1'b0;
        wait_clk(20);
        reset = 1'b0;
        rx = 1'b1;
        wait_clk(1);
        chk("midframe_reset_idle", 32'(dut.current_state), ST_IDLE);
        wait_clk(2);
        reset = 1'b1;
        wait_clk(700);
        chk("midframe_no_strobes", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
        send_frame(8'h81);
        chk("frame81_d_out", {24'd0, d_out}, 32'h81);

        wait_clk(100);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
